nes_cpu_mem_map: RTL and testbench

// - Parametrised CPU-side memory map for the NES core; sits between the 6502 bus master and the program stores.
// - Decodes the address, mirrors internal work RAM (2KB across $0000-$1FFF), mirrors PRG ROM (16KB or 32KB images) and selects the ROM by game.
// - Each access is a req/ready transaction with a configurable ROM latency; unmapped reads return open-bus data.

---
 rtl/nes_cpu_mem_map.sv | 203 ++++++++++++++++++++
 tb/tb_nes_cpu_mem_map.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_cpu_mem_map.sv
// CPU-side memory map for the NES core: work-RAM mirroring, PRG ROM mirroring and game select.
// Optional RAM_CLEAR_EN zeroes work RAM after reset and whenever the game select changes.
module nes_cpu_mem_map #(
  parameter int unsigned RAM_AW    = 11,
  parameter int unsigned PRG_AW    = 15,
  parameter int unsigned NUM_GAMES = 3,
  parameter int unsigned GAME_W    = 4,
  parameter int unsigned ROM_LAT   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic                   we,
  input  logic [15:0]            addr,
  input  logic [7:0]             wdata,
  output logic [7:0]             rdata,
  output logic                   ready,
  output logic                   busy,
  input  logic [GAME_W-1:0]      game,
  input  logic                   prg_16k,
  output logic [PRG_AW-1:0]      rom_addr,
  output logic                   rom_rd,
  input  logic [NUM_GAMES*8-1:0] rom_q,
  output logic [RAM_AW-1:0]      ram_addr_peek
);

  localparam int unsigned RAM_DEPTH = 2 ** RAM_AW;
  localparam int unsigned CNT_W     = $clog2(ROM_LAT + 1);

  localparam logic [2:0] IDLE     = 3'd1;
  localparam logic [2:0] RAM_RD   = 3'd2;
  localparam logic [2:0] ROM_WAIT = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;
`ifdef RAM_CLEAR_EN
  localparam logic [2:0] CLEAR     = 3'd0;
  localparam logic [2:0] RST_STATE = CLEAR;
`else
  localparam logic [2:0] RST_STATE = IDLE;
`endif

  // Clears bit 14 so a 16KB image appears at both $8000 and $C000.
  localparam logic [PRG_AW-1:0] MASK_16K = ~(PRG_AW'(1) << 14);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              rom_rd_q, rom_rd_d;
  logic [PRG_AW-1:0] rom_addr_q, rom_addr_d;
  logic [RAM_AW-1:0] peek_q, peek_d;
  logic [GAME_W-1:0] game_q, game_d;

  logic              is_ram, is_rom;
  logic [PRG_AW-1:0] rom_idx;
  logic [7:0]        rom_byte;

  logic [7:0]        ram [RAM_DEPTH];
  logic [7:0]        ram_dout;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr;
  logic [7:0]        ram_wdata;

`ifdef RAM_CLEAR_EN
  logic [RAM_AW-1:0] clr_idx_q, clr_idx_d;
  logic [GAME_W-1:0] game_seen_q, game_seen_d;
`endif

  assign is_ram  = (addr < 16'h2000);
  assign is_rom  = addr[15];
  assign rom_idx = addr[PRG_AW-1:0] & (prg_16k ? MASK_16K : {PRG_AW{1'b1}});

  // Out-of-range game selects read back as a NOP opcode.
  always_comb begin
    rom_byte = 8'hEA;
    for (int g = 0; g < int'(NUM_GAMES); g++) begin
      if (game_q == GAME_W'(g)) rom_byte = rom_q[8*g +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    ram_dout <= ram[addr[RAM_AW-1:0]];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    rom_rd_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    peek_d     = peek_q;
    game_d     = game_q;
    ram_we     = 1'b0;
    ram_waddr  = addr[RAM_AW-1:0];
    ram_wdata  = wdata;
`ifdef RAM_CLEAR_EN
    clr_idx_d   = clr_idx_q;
    game_seen_d = game_seen_q;
`endif
    case (state_q)
`ifdef RAM_CLEAR_EN
      CLEAR: begin
        ram_we      = 1'b1;
        ram_waddr   = clr_idx_q;
        ram_wdata   = 8'h00;
        game_seen_d = game;
        if (game != game_seen_q) begin
          clr_idx_d = '0;
        end else if (&clr_idx_q) begin
          clr_idx_d = '0;
          state_d   = IDLE;
        end else begin
          clr_idx_d = clr_idx_q + RAM_AW'(1);
        end
      end
`endif
      IDLE: begin
`ifdef RAM_CLEAR_EN
        if (game != game_seen_q) begin
          game_seen_d = game;
          clr_idx_d   = '0;
          state_d     = CLEAR;
        end else
`endif
        if (req) begin
          game_d = game;
          if (is_ram) begin
            peek_d = addr[RAM_AW-1:0];
            if (we) begin
              ram_we  = 1'b1;
              state_d = DONE;
            end else begin
              state_d = RAM_RD;
            end
          end else if (is_rom && !we) begin
            rom_rd_d   = 1'b1;
            rom_addr_d = rom_idx;
            cnt_d      = '0;
            state_d    = ROM_WAIT;
          end else begin
            state_d = DONE;
          end
        end
      end
      RAM_RD: begin
        rdata_d = ram_dout;
        state_d = DONE;
      end
      ROM_WAIT: begin
        if (cnt_q == CNT_W'(ROM_LAT)) begin
          rdata_d = rom_byte;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      cnt_q      <= '0;
      rdata_q    <= 8'h00;
      rom_rd_q   <= 1'b0;
      rom_addr_q <= '0;
      peek_q     <= '0;
      game_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      rom_rd_q   <= rom_rd_d;
      rom_addr_q <= rom_addr_d;
      peek_q     <= peek_d;
      game_q     <= game_d;
    end
  end

`ifdef RAM_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_idx_q   <= '0;
      game_seen_q <= '0;
    end else begin
      clr_idx_q   <= clr_idx_d;
      game_seen_q <= game_seen_d;
    end
  end

  assign busy = (state_q == CLEAR);
`else
  assign busy = 1'b0;
`endif

  assign ready         = (state_q == DONE);
  assign rdata         = rdata_q;
  assign rom_rd        = rom_rd_q;
  assign rom_addr      = rom_addr_q;
  assign ram_addr_peek = peek_q;

endmodule

// File: tb/tb_nes_cpu_mem_map.sv
// Directed vector bench for nes_cpu_mem_map (ROM_LAT=2, three games); covers RAM_CLEAR_EN when defined.
module tb_nes_cpu_mem_map;

  localparam int unsigned RAM_AW    = 11;
  localparam int unsigned PRG_AW    = 15;
  localparam int unsigned NUM_GAMES = 3;
  localparam int unsigned GAME_W    = 4;
  localparam int unsigned ROM_LAT   = 2;
`ifdef RAM_CLEAR_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   req;
  logic                   we;
  logic [15:0]            addr;
  logic [7:0]             wdata;
  logic [7:0]             rdata;
  logic                   ready;
  logic                   busy;
  logic [GAME_W-1:0]      game;
  logic                   prg_16k;
  logic [PRG_AW-1:0]      rom_addr;
  logic                   rom_rd;
  logic [NUM_GAMES*8-1:0] rom_q;
  logic [RAM_AW-1:0]      ram_addr_peek;

  always #5 clk = ~clk;

  nes_cpu_mem_map #(
    .RAM_AW   (RAM_AW),
    .PRG_AW   (PRG_AW),
    .NUM_GAMES(NUM_GAMES),
    .GAME_W   (GAME_W),
    .ROM_LAT  (ROM_LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .busy         (busy),
    .game         (game),
    .prg_16k      (prg_16k),
    .rom_addr     (rom_addr),
    .rom_rd       (rom_rd),
    .rom_q        (rom_q),
    .ram_addr_peek(ram_addr_peek)
  );

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [7:0]  d;
    logic [3:0]  g;
    logic        p16;
    int          lat;
    logic [7:0]  rd;
    logic        rr;
    logic [14:0] ra;
    logic [10:0] peek;
  } vec_t;

  vec_t vecs[15];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_not_busy();
    for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
  endtask

  // One transaction; lat counts negedges after the accepting posedge until ready is seen.
  task automatic access(input logic w, input logic [15:0] a, input logic [7:0] d,
                        input logic [3:0] g, input logic p, output int lat,
                        output logic rr_seen, output logic rdy_after);
    @(negedge clk);
    game    = g;
    prg_16k = p;
    @(negedge clk);
    wait_not_busy();
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    lat     = -1;
    rr_seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rom_rd) rr_seen = 1'b1;
      if (ready) begin
        lat = i;
        break;
      end
    end
    @(negedge clk);
    rdy_after = ready;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   lat;
    logic rr;
    logic after;
    int   cnt;
    int   rdy_cnt;

    vecs[0]  = '{1'b1, 16'h0001, 8'h5A, 4'd0, 1'b0, 1, 8'h00, 1'b0, 15'h0000, 11'h001};
    vecs[1]  = '{1'b0, 16'h0801, 8'h00, 4'd0, 1'b0, 2, 8'h5A, 1'b0, 15'h0000, 11'h001};
    vecs[2]  = '{1'b0, 16'h1801, 8'h00, 4'd0, 1'b0, 2, 8'h5A, 1'b0, 15'h0000, 11'h001};
    vecs[3]  = '{1'b1, 16'h0000, 8'h11, 4'd0, 1'b0, 1, 8'h5A, 1'b0, 15'h0000, 11'h000};
    vecs[4]  = '{1'b0, 16'h0000, 8'h00, 4'd0, 1'b0, 2, 8'h11, 1'b0, 15'h0000, 11'h000};
    vecs[5]  = '{1'b0, 16'h4016, 8'h00, 4'd0, 1'b0, 1, 8'h11, 1'b0, 15'h0000, 11'h000};
    vecs[6]  = '{1'b1, 16'h8000, 8'h33, 4'd0, 1'b0, 1, 8'h11, 1'b0, 15'h0000, 11'h000};
    vecs[7]  = '{1'b1, 16'h17FF, 8'h99, 4'd0, 1'b0, 1, 8'h11, 1'b0, 15'h0000, 11'h7FF};
    vecs[8]  = '{1'b0, 16'h07FF, 8'h00, 4'd0, 1'b0, 2, 8'h99, 1'b0, 15'h0000, 11'h7FF};
    vecs[9]  = '{1'b0, 16'hFFFC, 8'h00, 4'd2, 1'b0, 4, 8'hC3, 1'b1, 15'h7FFC, 11'h7FF};
    vecs[10] = '{1'b0, 16'hC010, 8'h00, 4'd0, 1'b1, 4, 8'h3C, 1'b1, 15'h0010, 11'h7FF};
    vecs[11] = '{1'b0, 16'hC010, 8'h00, 4'd1, 1'b0, 4, 8'h77, 1'b1, 15'h4010, 11'h7FF};
    vecs[12] = '{1'b0, 16'h8000, 8'h00, 4'd3, 1'b0, 4, 8'hEA, 1'b1, 15'h0000, 11'h7FF};
    vecs[13] = '{1'b1, 16'h2000, 8'h44, 4'd3, 1'b0, 1, 8'hEA, 1'b0, 15'h0000, 11'h7FF};
    vecs[14] = '{1'b1, 16'hFFFF, 8'h55, 4'd3, 1'b0, 1, 8'hEA, 1'b0, 15'h0000, 11'h7FF};

    rst_n   = 1'b0;
    req     = 1'b0;
    we      = 1'b0;
    addr    = 16'h4016;
    wdata   = 8'h00;
    game    = '0;
    prg_16k = 1'b0;
    rom_q   = 24'hC3_77_3C;

    repeat (3) @(negedge clk);
    check("rst_rdata", 32'(rdata), 32'h00);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_busy", 32'(busy), 32'(BUSY_RST));
    check("rst_rom_rd", 32'(rom_rd), 32'h0);
    check("rst_rom_addr", 32'(rom_addr), 32'h0);
    check("rst_peek", 32'(ram_addr_peek), 32'h0);

`ifdef RAM_CLEAR_EN
    // Hold a request through the clear; it must not be served.
    req     = 1'b1;
    rst_n   = 1'b1;
    cnt     = 0;
    rdy_cnt = 0;
    while (busy && cnt < 5000) begin
      cnt++;
      @(negedge clk);
      if (ready) rdy_cnt++;
    end
    req = 1'b0;
    check("clear_busy_cycles", 32'(cnt), 32'd2048);
    check("clear_req_ignored", 32'(rdy_cnt), 32'd0);
    access(1'b0, 16'h07FF, 8'h00, 4'd0, 1'b0, lat, rr, after);
    check("clear_read_lat", 32'(lat), 32'd2);
    check("clear_read_data", 32'(rdata), 32'h00);
    @(negedge clk);
    game = 4'd1;
    @(negedge clk);
    check("clear_on_game_change", 32'(busy), 32'h1);
    wait_not_busy();
    check("clear_game_done", 32'(busy), 32'h0);
`else
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("busy_tied_low", 32'(busy), 32'h0);
`endif

    foreach (vecs[i]) begin
      access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].g, vecs[i].p16, lat, rr, after);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vecs[i].rd));
      check($sformatf("v%0d_rom_rd", i), 32'(rr), 32'(vecs[i].rr));
      check($sformatf("v%0d_ready_pulse", i), 32'(after), 32'h0);
      check($sformatf("v%0d_peek", i), 32'(ram_addr_peek), 32'(vecs[i].peek));
      if (vecs[i].rr) check($sformatf("v%0d_rom_addr", i), 32'(rom_addr), 32'(vecs[i].ra));
    end

    // Game/prg_16k change and a held request during ROM_WAIT must not disturb the access.
    @(negedge clk);
    game    = 4'd2;
    prg_16k = 1'b0;
    @(negedge clk);
    wait_not_busy();
    req  = 1'b1;
    we   = 1'b0;
    addr = 16'hFFFC;
    @(posedge clk);
    #1;
    game    = 4'd0;
    prg_16k = 1'b1;
    addr    = 16'h4016;
    lat     = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ready) begin
        lat = i;
        req = 1'b0;
        break;
      end
    end
    req = 1'b0;
    check("midtx_lat", 32'(lat), 32'd4);
    check("midtx_rdata", 32'(rdata), 32'hC3);
    check("midtx_rom_addr", 32'(rom_addr), 32'h7FFC);
    rdy_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready) rdy_cnt++;
    end
    check("midtx_no_extra_ready", 32'(rdy_cnt), 32'd0);

    // Reset asserted during ROM_WAIT aborts the access.
    @(negedge clk);
    game    = 4'd1;
    prg_16k = 1'b0;
    @(negedge clk);
    wait_not_busy();
    req  = 1'b1;
    addr = 16'h8004;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_rdata", 32'(rdata), 32'h00);
    check("abort_ready", 32'(ready), 32'h0);
    check("abort_rom_addr", 32'(rom_addr), 32'h0);
    check("abort_peek", 32'(ram_addr_peek), 32'h0);
    check("abort_busy", 32'(busy), 32'(BUSY_RST));
    rdy_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (ready) rdy_cnt++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (ready) rdy_cnt++;
    end
    check("abort_no_ready", 32'(rdy_cnt), 32'd0);
    access(1'b0, 16'h8000, 8'h00, 4'd1, 1'b0, lat, rr, after);
    check("post_reset_lat", 32'(lat), 32'd4);
    check("post_reset_rdata", 32'(rdata), 32'h77);
    check("post_reset_rom_rd", 32'(rr), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
